// File: rtl/path_tester_pkg.sv
// path_tester_pkg: shared state encoding and widths for the launch/capture controller
package path_tester_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, REPORT} state_t;
    localparam int DUT_IN_W  = 4;
    localparam int DUT_OUT_W = 2;
    localparam int CNT_W_DEF = 8;
    localparam int LAT_W_DEF = 3;
endpackage

// File: rtl/path_tester_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that overrides increment
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    assign q = cnt_q;
endmodule

// File: rtl/path_tester.sv
// path_tester: launches a pattern into a netlist, waits L cycles, captures and compares its outputs
module path_tester
    import path_tester_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DUT_IN_W-1:0]  pattern,
    input  logic [DUT_OUT_W-1:0] expect_val,
    input  logic [LAT_W-1:0]     capture_lat,
    input  logic                 clear_count,
    input  logic [DUT_OUT_W-1:0] dut_out,
    output logic [DUT_IN_W-1:0]  dut_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [DUT_OUT_W-1:0] mismatch,
    output logic [CNT_W-1:0]     fail_count
);
    state_t                 state_q, state_d;
    logic [DUT_IN_W-1:0]    dut_in_q, dut_in_d;
    logic [DUT_OUT_W-1:0]   exp_q, exp_d, mis_q, mis_d;
    logic [LAT_W-1:0]       lat_q, lat_d, cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        dut_in_d = dut_in_q;
        exp_d    = exp_q;
        lat_d    = lat_q;
        cnt_d    = cnt_q;
        mis_d    = mis_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = LAUNCH;
                dut_in_d = pattern;
                exp_d    = expect_val;
                lat_d    = capture_lat;
                mis_d    = '0;
            end
            LAUNCH: if (lat_q == '0) begin
                state_d = REPORT;
                mis_d   = dut_out ^ exp_q;
            end else begin
                state_d = WAIT;
                cnt_d   = lat_q - LAT_W'(1);
            end
            WAIT: if (cnt_q == '0) begin
                state_d = REPORT;
                mis_d   = dut_out ^ exp_q;
            end else begin
                cnt_d = cnt_q - LAT_W'(1);
            end
            REPORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q  <= IDLE;
            dut_in_q <= '0;
            exp_q    <= '0;
            lat_q    <= '0;
            cnt_q    <= '0;
            mis_q    <= '0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            exp_q    <= exp_d;
            lat_q    <= lat_d;
            cnt_q    <= cnt_d;
            mis_q    <= mis_d;
        end

    assign dut_in   = dut_in_q;
    assign busy     = state_q != IDLE;
    assign done     = state_q == REPORT;
    assign fail     = done & |mis_q;
    assign pass     = done & ~|mis_q;
    assign mismatch = mis_q;

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear_count),
        .inc (fail),
        .q   (fail_count)
    );
endmodule

// File: tb/tb_path_tester.sv
// tb_path_tester: randomized scoreboard bench for path_tester with a run-level reference model
module tb_path_tester;
    import path_tester_pkg::*;
    localparam int CW = 2;
    localparam int LW = 3;
    localparam int MAXC = (1 << CW) - 1;

    logic clk, rst, start, clear_count, busy, done, pass, fail;
    logic [3:0] pattern, dut_in;
    logic [1:0] expect_val, dut_out, mismatch;
    logic [LW-1:0] capture_lat;
    logic [CW-1:0] fail_count;

    path_tester #(.CNT_W(CW), .LAT_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .expect_val(expect_val),
        .capture_lat(capture_lat), .clear_count(clear_count), .dut_out(dut_out),
        .dut_in(dut_in), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .mismatch(mismatch), .fail_count(fail_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] mis;
        logic [3:0] pat;
        int         cnt;
    } item_t;
    item_t sb[$];

    int total = 0, bad = 0, cnt_m = 0;

    task automatic chk(string n, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", n, act, exp, cyc);
        end
    endtask

    task automatic push(int k, int l, logic [1:0] mis, logic [3:0] p, bit clr);
        item_t it;
        it.cyc = k + 1 + l;
        it.mis = mis;
        it.pat = p;
        it.cnt = cnt_m;
        sb.push_back(it);
        cnt_m = clr ? 0 : (mis != 0 && cnt_m < MAXC) ? cnt_m + 1 : cnt_m;
    endtask

    always @(negedge clk) begin : mon
        item_t it;
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    it = sb.pop_front();
                    chk("done_cycle", cyc, it.cyc);
                    chk("mismatch", int'(mismatch), int'(it.mis));
                    chk("pass", int'(pass), int'(it.mis == 0));
                    chk("fail", int'(fail), int'(it.mis != 0));
                    chk("dut_in_hold", int'(dut_in), int'(it.pat));
                    chk("count_at_report", int'(fail_count), it.cnt);
                end
            end else begin
                chk("pass_fail_idle", int'({pass, fail}), 0);
            end
        end
    end

    // dut_out switches from v0 to v1 after edge k+c; the sample at edge k+1+l sees v1 only if c <= l
    task automatic run(logic [3:0] p, logic [1:0] e, int l, logic [1:0] v0, logic [1:0] v1, int c, bit clr);
        int k;
        logic [1:0] seen;
        @(negedge clk);
        pattern = p; expect_val = e; capture_lat = LW'(l); dut_out = v0; start = 1;
        k = cyc + 1;
        seen = (c <= l) ? v1 : v0;
        push(k, l, seen ^ e, p, clr);
        for (int t = 0; t <= l + 2; t++) begin
            @(negedge clk);
            if (t == 0) chk("dut_in_launch", int'(dut_in), int'(p));
            chk("busy", int'(busy), int'(t <= l + 1));
            start = (t <= l + 1) ? 1'($urandom) : 1'b0;
            pattern = 4'($urandom); expect_val = 2'($urandom); capture_lat = LW'($urandom);
            if (t == c) dut_out = v1;
            clear_count = clr && t == l + 1;
        end
        chk("count_after", int'(fail_count), cnt_m);
        chk("mismatch_held", int'(mismatch), int'(seen ^ e));
    endtask

    initial begin
        int l;
        logic [1:0] e, v;
        rst = 1; start = 0; pattern = 0; expect_val = 0; capture_lat = 0; clear_count = 0; dut_out = 0;
        repeat (2) @(negedge clk);
        chk("rst_dut_in", int'(dut_in), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass_fail", int'({pass, fail}), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_count", int'(fail_count), 0);
        rst = 0;

        run(4'b1010, 2'b01, 0, 2'b01, 2'b01, 1, 0);
        run(4'b0101, 2'b11, 5, 2'b11, 2'b10, 5, 0);
        for (int i = 0; i < 4; i++) run(4'($urandom), 2'b00, i, 2'b11, 2'b11, 1, 0);
        run(4'b1111, 2'b10, 1, 2'b01, 2'b01, 2, 1);

        for (int i = 0; i < 25; i++) begin
            l = $urandom_range(0, 7);
            run(4'($urandom), 2'($urandom), l, 2'($urandom), 2'($urandom),
                $urandom_range(1, l + 1), $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        pattern = 4'b0110; capture_lat = 7; start = 1;
        @(negedge clk);
        start = 0;
        chk("mid_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        #1 rst = 1;
        #1;
        chk("async_dut_in", int'(dut_in), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_count", int'(fail_count), 0);
        cnt_m = 0;
        @(negedge clk);
        rst = 0;
        repeat (10) @(negedge clk);
        run(4'b1001, 2'b10, 3, 2'b10, 2'b00, 4, 0);

        @(negedge clk);
        e = 2'($urandom); v = 2'($urandom);
        expect_val = e; dut_out = v; capture_lat = 2; clear_count = 0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) @(negedge clk);
            pattern = 4'($urandom);
            start = 1;
            if (i % 5 == 0) push(cyc + 1, 2, v ^ e, pattern, 0);
        end
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        chk("held_start_count", int'(fail_count), cnt_m);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
